// File: rtl/shift_norm_pkg.sv
// Shared types and constants for the sequential shift normalizer.
// Included by the normalizer top and its per-stage datapath.
package shift_norm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH  = 32;
    localparam int STAGES = 5;
    localparam int CNT_W  = 6;

    localparam logic [CNT_W-1:0] ZERO_COUNT = 6'd32;

    localparam logic MODE_LEFT  = 1'b0;
    localparam logic MODE_RIGHT = 1'b1;

endpackage

// File: rtl/norm_step.sv
// One stage of the 16/8/4/2/1 normalize decomposition: tests the edge field
// of the work word and shifts it out when that field is all zeros.
module norm_step
    import shift_norm_pkg::*;
(
    input  logic [WIDTH-1:0] work,
    input  logic [2:0]       index,
    input  logic             mode,
    output logic [WIDTH-1:0] next_work,
    output logic             take
);

    logic [4:0]       shamt;
    logic [WIDTH-1:0] hi_mask;
    logic [WIDTH-1:0] lo_mask;

    // Indices past the last stage yield a zero shift and never take.
    always_comb begin
        shamt     = 5'd16 >> index;
        hi_mask   = ~({WIDTH{1'b1}} >> shamt);
        lo_mask   = ~({WIDTH{1'b1}} << shamt);
        next_work = work;
        take      = 1'b0;
        if (index < 3'(STAGES)) begin
            if (mode == MODE_LEFT) begin
                take = ((work & hi_mask) == '0);
                if (take) begin
                    next_work = work << shamt;
                end
            end else begin
                take = ((work & lo_mask) == '0);
                if (take) begin
                    next_work = work >> shamt;
                end
            end
        end
    end

endmodule

// File: rtl/shift_normalizer.sv
// Multi-cycle CLZ/CTZ normalizer: one barrel stage per cycle behind a
// valid/ready handshake, constant 5-cycle latency including the zero operand.
module shift_normalizer
    import shift_norm_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic             i_mode,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_norm,
    output logic [CNT_W-1:0] o_count,
    output logic             o_zero
);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] work_q;
    logic             mode_q;
    logic             zero_q;
    logic [CNT_W-1:0] count_q;
    logic [2:0]       index_q;
    logic             ready_q;
    logic             valid_q;

    logic [WIDTH-1:0] step_work;
    logic             step_take;
    logic [CNT_W-1:0] step_amt;
    logic [WIDTH-1:0] stage_work;
    logic [CNT_W-1:0] stage_count;
    logic             last_stage;
    logic             accept;

    norm_step u_step (
        .work      (work_q),
        .index     (index_q),
        .mode      (mode_q),
        .next_work (step_work),
        .take      (step_take)
    );

    assign o_ready = ready_q;
    assign o_valid = valid_q;

    always_comb begin
        step_amt    = CNT_W'(5'd16 >> index_q);
        stage_work  = step_take ? step_work : work_q;
        stage_count = step_take ? (count_q + step_amt) : count_q;
        last_stage  = (index_q == 3'(STAGES - 1));
        accept      = (state == IDLE) && i_valid && ready_q;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept)     next_state = RUN;
            RUN:     if (last_stage) next_state = DONE;
            DONE:    if (i_ready)    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake flags are registered from next_state so o_ready stays low
    // until the first edge after reset is released.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            work_q  <= '0;
            mode_q  <= MODE_LEFT;
            zero_q  <= 1'b0;
            count_q <= '0;
            index_q <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            o_norm  <= '0;
            o_count <= '0;
            o_zero  <= 1'b0;
        end else begin
            state   <= next_state;
            ready_q <= (next_state == IDLE);
            valid_q <= (next_state == DONE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        work_q  <= i_a;
                        mode_q  <= i_mode;
                        zero_q  <= (i_a == '0);
                        count_q <= '0;
                        index_q <= '0;
                    end
                end
                RUN: begin
                    work_q  <= stage_work;
                    count_q <= stage_count;
                    index_q <= index_q + 3'd1;
                    // A zero operand would otherwise report 31 shifts.
                    if (last_stage) begin
                        o_norm  <= zero_q ? '0 : stage_work;
                        o_count <= zero_q ? ZERO_COUNT : stage_count;
                        o_zero  <= zero_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_normalizer.sv
// Directed self-checking bench for shift_normalizer: counts, zero operand,
// latency, backpressure and reset abort with hand-computed expectations.
module tb_shift_normalizer;
    import shift_norm_pkg::*;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_a;
    logic        i_mode;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_norm;
    logic [5:0]  o_count;
    logic        o_zero;

    int checks = 0;
    int errors = 0;

    shift_normalizer dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (i_a),
        .i_mode  (i_mode),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_norm  (o_norm),
        .o_count (o_count),
        .o_zero  (o_zero)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Waits for o_ready, issues one request and counts edges until o_valid.
    task automatic applyStimulus(input string tag, input logic [31:0] a,
                                 input logic mode, output int latency);
        int guard;
        guard   = 0;
        i_a     = a;
        i_mode  = mode;
        i_valid = 1'b1;
        while (o_ready !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        tick();
        i_valid = 1'b0;
        i_a     = ~a;
        i_mode  = ~mode;
        checkOutput({tag, "_ready_drop"}, {31'd0, o_ready}, 32'd0);
        latency = 0;
        while (o_valid !== 1'b1 && latency < 20) begin
            tick();
            latency++;
        end
    endtask

    task automatic runOp(input string tag, input logic [31:0] a, input logic mode,
                         input logic [31:0] exp_norm, input logic [5:0] exp_count,
                         input logic exp_zero);
        int lat;
        applyStimulus(tag, a, mode, lat);
        checkOutput({tag, "_latency"}, 32'(lat), 32'd5);
        checkOutput({tag, "_norm"}, o_norm, exp_norm);
        checkOutput({tag, "_count"}, {26'd0, o_count}, {26'd0, exp_count});
        checkOutput({tag, "_zero"}, {31'd0, o_zero}, {31'd0, exp_zero});
        tick();
        checkOutput({tag, "_valid_after"}, {31'd0, o_valid}, 32'd0);
        checkOutput({tag, "_ready_after"}, {31'd0, o_ready}, 32'd1);
    endtask

    initial begin
        int  lat;
        logic seen_valid;

        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_a     = 32'h0;
        i_mode  = MODE_LEFT;
        i_ready = 1'b1;
        tick();
        tick();
        checkOutput("rst_ready", {31'd0, o_ready}, 32'd0);
        checkOutput("rst_valid", {31'd0, o_valid}, 32'd0);
        checkOutput("rst_norm", o_norm, 32'd0);
        checkOutput("rst_count", {26'd0, o_count}, 32'd0);
        checkOutput("rst_zero", {31'd0, o_zero}, 32'd0);
        i_rst_n = 1'b1;
        tick();
        checkOutput("rel_ready", {31'd0, o_ready}, 32'd1);

        runOp("left16", 32'h0001_0000, MODE_LEFT,  32'h8000_0000, 6'd15, 1'b0);
        runOp("right16", 32'h0001_0000, MODE_RIGHT, 32'h0000_0001, 6'd16, 1'b0);
        runOp("zero_l", 32'h0000_0000, MODE_LEFT,  32'h0000_0000, 6'd32, 1'b1);
        runOp("zero_r", 32'h0000_0000, MODE_RIGHT, 32'h0000_0000, 6'd32, 1'b1);
        runOp("norm_l", 32'h8000_0000, MODE_LEFT,  32'h8000_0000, 6'd0,  1'b0);
        runOp("ones_r", 32'hFFFF_FFFF, MODE_RIGHT, 32'hFFFF_FFFF, 6'd0,  1'b0);
        runOp("one_l", 32'h0000_0001, MODE_LEFT,  32'h8000_0000, 6'd31, 1'b0);
        runOp("msb_r", 32'h8000_0000, MODE_RIGHT, 32'h0000_0001, 6'd31, 1'b0);

        // Backpressure: result held, second request waits for IDLE.
        i_ready = 1'b0;
        applyStimulus("bp", 32'h0000_0100, MODE_LEFT, lat);
        checkOutput("bp_latency", 32'(lat), 32'd5);
        i_a     = 32'h0000_0F00;
        i_mode  = MODE_RIGHT;
        i_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("bp_hold_valid", {31'd0, o_valid}, 32'd1);
            checkOutput("bp_hold_norm", o_norm, 32'h8000_0000);
            checkOutput("bp_hold_count", {26'd0, o_count}, 32'd23);
            checkOutput("bp_hold_ready", {31'd0, o_ready}, 32'd0);
        end
        i_ready = 1'b1;
        tick();
        checkOutput("bp_hs_valid", {31'd0, o_valid}, 32'd0);
        checkOutput("bp_hs_ready", {31'd0, o_ready}, 32'd1);
        tick();
        i_valid = 1'b0;
        checkOutput("bp_second_accept", {31'd0, o_ready}, 32'd0);
        lat = 0;
        while (o_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        checkOutput("bp2_latency", 32'(lat), 32'd5);
        checkOutput("bp2_norm", o_norm, 32'h0000_000F);
        checkOutput("bp2_count", {26'd0, o_count}, 32'd8);
        tick();

        // Reset three edges after acceptance aborts the request.
        i_a     = 32'h1234_5678;
        i_mode  = MODE_LEFT;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        tick();
        i_rst_n = 1'b0;
        tick();
        checkOutput("abort_valid", {31'd0, o_valid}, 32'd0);
        checkOutput("abort_ready", {31'd0, o_ready}, 32'd0);
        i_rst_n    = 1'b1;
        seen_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            seen_valid = seen_valid | o_valid;
        end
        checkOutput("abort_no_valid", {31'd0, seen_valid}, 32'd0);
        checkOutput("abort_ready_back", {31'd0, o_ready}, 32'd1);
        runOp("post_rst", 32'h0000_0F00, MODE_RIGHT, 32'h0000_000F, 6'd8, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
